// File: rtl/simd_lane_unpack.sv
// Purpose : buffers packed FOUR12 DSP48 sums (P + CARRYOUT) and serializes the
//           four lane sums into a saturated OUT_W-bit pixel stream.
// Latency : a word sampled on edge E0 into an empty block is presented as lane 0
//           after edge E2; one lane per cycle afterwards.
// Backpr. : the output holds while m_valid_o && !m_ready_i. The input cannot be
//           stalled, so s_afull_o asks upstream to gate CE. Words that arrive
//           while the FIFO is full are dropped and counted.
// Ports   : clk_i/rst_i (async active-high); s_valid_i/s_p_i/s_carry_i packed
//           input word; s_afull_o occupancy >= DEPTH-1; m_valid_o/m_ready_i/
//           m_data_o/m_lane_o/m_last_o/m_sat_o pixel stream; drop_cnt_o
//           saturating count of dropped words.
module simd_lane_unpack #(
   parameter int LANE_W = 12,
   parameter int OUT_W  = 8,
   parameter int DEPTH  = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                s_valid_i,
   input  logic [4*LANE_W-1:0] s_p_i,
   input  logic [3:0]          s_carry_i,
   output logic                s_afull_o,
   output logic                m_valid_o,
   input  logic                m_ready_i,
   output logic [OUT_W-1:0]    m_data_o,
   output logic [1:0]          m_lane_o,
   output logic                m_last_o,
   output logic                m_sat_o,
   output logic [15:0]         drop_cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [3:0]          carry;
      logic [4*LANE_W-1:0] p;
   } word_t;

   word_t             mem [DEPTH];
   word_t             head;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [CW-1:0]     count_nxt;
   logic              wr_q;
   logic [1:0]        lane_cnt;

   logic              full;
   logic              wr_en;
   logic              drop;
   logic              visible;
   logic              out_free;
   logic              load;
   logic              pop;

   logic [LANE_W-1:0] lane_sum;
   logic              lane_carry;
   logic [LANE_W:0]   lane_v;
   logic              lane_sat;
   logic [OUT_W-1:0]  lane_pix;

   // Full decision uses the pre-edge count: a pop on the same edge does not
   // make room for an arriving word.
   assign full  = (count == CW'(DEPTH));
   assign wr_en = s_valid_i && !full;
   assign drop  = s_valid_i && full;

   // The word written on the previous edge is not yet readable; it becomes
   // visible to the serializer one cycle later, giving the E0 -> E2 latency.
   // Only the newest entry can be that fresh word, so any older entry counts.
   assign visible  = (count > CW'(1)) || ((count == CW'(1)) && !wr_q);
   assign out_free = !m_valid_o || m_ready_i;
   assign load     = out_free && visible;
   assign pop      = load && (lane_cnt == 2'd3);

   always_comb begin
      count_nxt = count;
      if (wr_en && !pop) begin
         count_nxt = count + 1'b1;
      end else if (!wr_en && pop) begin
         count_nxt = count - 1'b1;
      end
   end

   // Lane extraction and saturation: {carry, sum} exceeds the pixel range
   // whenever any bit at or above OUT_W is set, so a carry always clips.
   assign head       = mem[rd_ptr];
   assign lane_sum   = head.p[lane_cnt*LANE_W +: LANE_W];
   assign lane_carry = head.carry[lane_cnt];
   assign lane_v     = {lane_carry, lane_sum};
   assign lane_sat   = |lane_v[LANE_W:OUT_W];
   assign lane_pix   = lane_sat ? '1 : lane_v[OUT_W-1:0];

   // Storage carries no reset; pointers and count define what is valid.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_ptr] <= '{carry: s_carry_i, p: s_p_i};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         wr_q       <= 1'b0;
         s_afull_o  <= 1'b0;
         drop_cnt_o <= 16'd0;
         lane_cnt   <= 2'd0;
         m_valid_o  <= 1'b0;
         m_data_o   <= '0;
         m_lane_o   <= 2'd0;
         m_last_o   <= 1'b0;
         m_sat_o    <= 1'b0;
      end else begin
         count     <= count_nxt;
         wr_q      <= wr_en;
         s_afull_o <= (count_nxt >= CW'(DEPTH - 1));

         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (drop && (drop_cnt_o != 16'hFFFF)) begin
            drop_cnt_o <= drop_cnt_o + 16'd1;
         end

         if (out_free) begin
            if (load) begin
               m_valid_o <= 1'b1;
               m_data_o  <= lane_pix;
               m_lane_o  <= lane_cnt;
               m_last_o  <= (lane_cnt == 2'd3);
               m_sat_o   <= lane_sat;
               lane_cnt  <= lane_cnt + 2'd1;
            end else begin
               m_valid_o <= 1'b0;
            end
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_simd_lane_unpack.sv
module tb_simd_lane_unpack;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] lane;
      logic       last;
      logic       sat;
   } pix_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic [47:0] s_p;
   logic [3:0]  s_carry;
   logic        s_afull;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  m_data;
   logic [1:0]  m_lane;
   logic        m_last;
   logic        m_sat;
   logic [15:0] drop_cnt;

   int   vectors = 0;
   int   miscompares = 0;
   int   chk_idx = 0;
   pix_t exp_q[$];
   pix_t got_q[$];

   simd_lane_unpack #(.LANE_W(12), .OUT_W(8), .DEPTH(4)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .s_valid_i  (s_valid),
      .s_p_i      (s_p),
      .s_carry_i  (s_carry),
      .s_afull_o  (s_afull),
      .m_valid_o  (m_valid),
      .m_ready_i  (m_ready),
      .m_data_o   (m_data),
      .m_lane_o   (m_lane),
      .m_last_o   (m_last),
      .m_sat_o    (m_sat),
      .drop_cnt_o (drop_cnt)
   );

   always #5 clk = ~clk;

   // Record every pixel that will be handshaken on the coming rising edge.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         got_q.push_back(pix_t'({m_data, m_lane, m_last, m_sat}));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   function automatic pix_t mdl(input logic [47:0] p, input logic [3:0] c, input int k);
      logic [12:0] v;
      pix_t        r;
      v      = {c[k], p[12*k +: 12]};
      r.lane = 2'(k);
      r.last = (k == 3);
      if (v > 13'd255) begin
         r.data = 8'hFF;
         r.sat  = 1'b1;
      end else begin
         r.data = v[7:0];
         r.sat  = 1'b0;
      end
      return r;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [47:0] p, input logic [3:0] c);
      s_valid = 1'b1;
      s_p     = p;
      s_carry = c;
      cyc();
      s_valid = 1'b0;
   endtask

   task automatic push_word(input logic [47:0] p, input logic [3:0] c);
      for (int k = 0; k < 4; k++) exp_q.push_back(mdl(p, c, k));
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0; s_p = '0; s_carry = '0; m_ready = 1'b0;
      cyc(); cyc();
      vectors++;
      if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b required 0", m_valid); end
      vectors++;
      if ({m_data, m_lane, m_last, m_sat} !== 12'd0) begin
         miscompares++; $display("FAIL reset_pixel: got %h required 000", {m_data, m_lane, m_last, m_sat});
      end
      vectors++;
      if (s_afull !== 1'b0 || drop_cnt !== 16'd0) begin
         miscompares++; $display("FAIL reset_flags: afull %b drop %h required 0 0000", s_afull, drop_cnt);
      end
      rst = 1'b0;
      repeat (3) cyc();
      vectors++;
      if (m_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid: got %b required 0", m_valid); end
   endtask

   task automatic test_single();
      logic [47:0] p = 48'h0FF10007F003;
      logic [3:0]  c = 4'b0100;
      pix_t        e;
      m_ready = 1'b1;
      push_word(p, c);
      write_word(p, c);
      vectors++;
      if (m_valid !== 1'b0) begin miscompares++; $display("FAIL lat_e0: valid %b required 0", m_valid); end
      cyc();
      vectors++;
      if (m_valid !== 1'b0) begin miscompares++; $display("FAIL lat_e1: valid %b required 0", m_valid); end
      cyc();
      vectors++;
      if (m_valid !== 1'b1 || m_lane !== 2'd0) begin
         miscompares++; $display("FAIL lat_e2: valid %b lane %0d required 1 0", m_valid, m_lane);
      end
      for (int i = 0; i < 60 && (got_q.size() - chk_idx) < exp_q.size(); i++) cyc();
      repeat (3) cyc();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (chk_idx >= got_q.size()) begin
            miscompares++; $display("FAIL single_stream: pixel missing, required %h", e);
         end else begin
            if (got_q[chk_idx] !== e) begin
               miscompares++; $display("FAIL single_stream: got %h required %h", got_q[chk_idx], e);
            end
            chk_idx++;
         end
      end
      vectors++;
      if (got_q.size() != chk_idx) begin
         miscompares++; $display("FAIL single_extra: %0d extra pixels, required 0", got_q.size() - chk_idx);
         chk_idx = got_q.size();
      end
   endtask

   task automatic test_carry_sat();
      pix_t e;
      m_ready = 1'b1;
      push_word(48'h0, 4'b1111);
      write_word(48'h0, 4'b1111);
      for (int i = 0; i < 60 && (got_q.size() - chk_idx) < exp_q.size(); i++) cyc();
      repeat (3) cyc();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (chk_idx >= got_q.size()) begin
            miscompares++; $display("FAIL carry_stream: pixel missing, required %h", e);
         end else begin
            if (got_q[chk_idx] !== e) begin
               miscompares++; $display("FAIL carry_stream: got %h required %h", got_q[chk_idx], e);
            end
            chk_idx++;
         end
      end
      vectors++;
      if (got_q.size() != chk_idx) begin
         miscompares++; $display("FAIL carry_extra: %0d extra pixels, required 0", got_q.size() - chk_idx);
         chk_idx = got_q.size();
      end
   endtask

   task automatic test_back_to_back();
      logic [47:0] p0 = 48'h0123_4567_89AB;
      logic [47:0] p1 = 48'h00F_0FE_080_001;
      pix_t        e;
      m_ready = 1'b1;
      push_word(p0, 4'b1010);
      push_word(p1, 4'b0000);
      write_word(p0, 4'b1010);
      write_word(p1, 4'b0000);
      for (int i = 0; i < 10 && !m_valid; i++) cyc();
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (m_valid !== 1'b1) begin
            miscompares++; $display("FAIL b2b_bubble: cycle %0d valid %b required 1", i, m_valid);
         end
         cyc();
      end
      for (int i = 0; i < 60 && (got_q.size() - chk_idx) < exp_q.size(); i++) cyc();
      repeat (3) cyc();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (chk_idx >= got_q.size()) begin
            miscompares++; $display("FAIL b2b_stream: pixel missing, required %h", e);
         end else begin
            if (got_q[chk_idx] !== e) begin
               miscompares++; $display("FAIL b2b_stream: got %h required %h", got_q[chk_idx], e);
            end
            chk_idx++;
         end
      end
      vectors++;
      if (got_q.size() != chk_idx) begin
         miscompares++; $display("FAIL b2b_extra: %0d extra pixels, required 0", got_q.size() - chk_idx);
         chk_idx = got_q.size();
      end
   endtask

   task automatic test_backpressure();
      logic [47:0] p = 48'h5A5_0C8_3FF_012;
      logic [3:0]  c = 4'b0001;
      logic [7:0]  d0;
      logic [1:0]  l0;
      logic        s0;
      pix_t        e;
      m_ready = 1'b0;
      push_word(p, c);
      write_word(p, c);
      for (int i = 0; i < 10 && !m_valid; i++) cyc();
      vectors++;
      if (m_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid: got %b required 1 within 10 cycles", m_valid); end
      d0 = m_data; l0 = m_lane; s0 = m_sat;
      vectors++;
      if (l0 !== 2'd0) begin miscompares++; $display("FAIL bp_first_lane: got %0d required 0", l0); end
      for (int i = 0; i < 10; i++) begin
         cyc();
         vectors++;
         if (m_valid !== 1'b1 || m_data !== d0 || m_lane !== l0 || m_sat !== s0) begin
            miscompares++;
            $display("FAIL bp_hold: cycle %0d got v%b d%h l%0d s%b required v1 d%h l%0d s%b",
                     i, m_valid, m_data, m_lane, m_sat, d0, l0, s0);
         end
      end
      m_ready = 1'b1;
      for (int i = 0; i < 60 && (got_q.size() - chk_idx) < exp_q.size(); i++) cyc();
      repeat (3) cyc();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (chk_idx >= got_q.size()) begin
            miscompares++; $display("FAIL bp_stream: pixel missing, required %h", e);
         end else begin
            if (got_q[chk_idx] !== e) begin
               miscompares++; $display("FAIL bp_stream: got %h required %h", got_q[chk_idx], e);
            end
            chk_idx++;
         end
      end
      vectors++;
      if (got_q.size() != chk_idx) begin
         miscompares++; $display("FAIL bp_extra: %0d extra pixels, required 0", got_q.size() - chk_idx);
         chk_idx = got_q.size();
      end
   endtask

   task automatic test_overflow();
      logic [47:0] p;
      logic [3:0]  c;
      pix_t        e;
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         p = {16'($urandom), 32'($urandom)};
         c = 4'($urandom);
         if (i < 4) push_word(p, c);
         write_word(p, c);
         if (i == 1) begin
            vectors++;
            if (s_afull !== 1'b0) begin miscompares++; $display("FAIL ovf_afull_2: got %b required 0", s_afull); end
         end
         if (i == 2) begin
            vectors++;
            if (s_afull !== 1'b1) begin miscompares++; $display("FAIL ovf_afull_3: got %b required 1", s_afull); end
         end
      end
      vectors++;
      if (drop_cnt !== 16'd2) begin miscompares++; $display("FAIL ovf_drops: got %0d required 2", drop_cnt); end
      m_ready = 1'b1;
      for (int i = 0; i < 80 && (got_q.size() - chk_idx) < exp_q.size(); i++) cyc();
      repeat (3) cyc();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (chk_idx >= got_q.size()) begin
            miscompares++; $display("FAIL ovf_stream: pixel missing, required %h", e);
         end else begin
            if (got_q[chk_idx] !== e) begin
               miscompares++; $display("FAIL ovf_stream: got %h required %h", got_q[chk_idx], e);
            end
            chk_idx++;
         end
      end
      vectors++;
      if (got_q.size() != chk_idx) begin
         miscompares++; $display("FAIL ovf_extra: %0d extra pixels, required 0", got_q.size() - chk_idx);
         chk_idx = got_q.size();
      end
      vectors++;
      if (s_afull !== 1'b0) begin miscompares++; $display("FAIL ovf_afull_drained: got %b required 0", s_afull); end
   endtask

   task automatic test_full_pop();
      logic [47:0] p;
      logic [3:0]  c;
      logic [15:0] d_before;
      pix_t        e;
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         p = {16'($urandom), 32'($urandom)};
         c = 4'($urandom);
         push_word(p, c);
         write_word(p, c);
      end
      m_ready = 1'b1;
      for (int i = 0; i < 10 && !(m_valid && m_lane == 2'd2); i++) cyc();
      vectors++;
      if (m_valid !== 1'b1 || m_lane !== 2'd2) begin
         miscompares++; $display("FAIL fp_reach_lane2: valid %b lane %0d required 1 2", m_valid, m_lane);
      end
      d_before = drop_cnt;
      // Pop edge and write arrive together; this word must be lost.
      write_word(48'hABC_DEF_123_456, 4'b1111);
      m_ready = 1'b0;
      vectors++;
      if (drop_cnt !== d_before + 16'd1) begin
         miscompares++; $display("FAIL fp_drop: got %0d required %0d", drop_cnt, d_before + 16'd1);
      end
      vectors++;
      if (s_afull !== 1'b1) begin miscompares++; $display("FAIL fp_afull: got %b required 1", s_afull); end
      // Exactly one slot should now be free.
      p = 48'h010_020_030_040; c = 4'b0000;
      push_word(p, c);
      write_word(p, c);
      vectors++;
      if (drop_cnt !== d_before + 16'd1) begin
         miscompares++; $display("FAIL fp_one_slot: drops %0d required %0d", drop_cnt, d_before + 16'd1);
      end
      write_word(48'h111_222_333_444, 4'b0000);
      vectors++;
      if (drop_cnt !== d_before + 16'd2) begin
         miscompares++; $display("FAIL fp_full_again: drops %0d required %0d", drop_cnt, d_before + 16'd2);
      end
      m_ready = 1'b1;
      for (int i = 0; i < 80 && (got_q.size() - chk_idx) < exp_q.size(); i++) cyc();
      repeat (3) cyc();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (chk_idx >= got_q.size()) begin
            miscompares++; $display("FAIL fp_stream: pixel missing, required %h", e);
         end else begin
            if (got_q[chk_idx] !== e) begin
               miscompares++; $display("FAIL fp_stream: got %h required %h", got_q[chk_idx], e);
            end
            chk_idx++;
         end
      end
      vectors++;
      if (got_q.size() != chk_idx) begin
         miscompares++; $display("FAIL fp_extra: %0d extra pixels, required 0", got_q.size() - chk_idx);
         chk_idx = got_q.size();
      end
   endtask

   task automatic test_reset_mid();
      logic [47:0] p = 48'h0AA_0BB_0CC_0DD;
      logic [3:0]  c = 4'b0000;
      logic [47:0] q = 48'h007_006_005_104;
      pix_t        e;
      m_ready = 1'b1;
      exp_q.push_back(mdl(p, c, 0));
      exp_q.push_back(mdl(p, c, 1));
      write_word(p, c);
      for (int i = 0; i < 10 && !(m_valid && m_lane == 2'd1); i++) cyc();
      vectors++;
      if (m_valid !== 1'b1 || m_lane !== 2'd1) begin
         miscompares++; $display("FAIL rm_reach_lane1: valid %b lane %0d required 1 1", m_valid, m_lane);
      end
      cyc();
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({m_valid, m_lane, m_last, m_sat, s_afull} !== 6'd0) begin
         miscompares++; $display("FAIL rm_ctrl: got %b required 000000", {m_valid, m_lane, m_last, m_sat, s_afull});
      end
      vectors++;
      if (m_data !== 8'd0) begin miscompares++; $display("FAIL rm_data: got %h required 00", m_data); end
      vectors++;
      if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL rm_drops: got %0d required 0", drop_cnt); end
      cyc(); cyc();
      rst = 1'b0;
      cyc();
      push_word(q, 4'b0010);
      write_word(q, 4'b0010);
      for (int i = 0; i < 10 && !m_valid; i++) cyc();
      vectors++;
      if (m_valid !== 1'b1 || m_lane !== 2'd0 || drop_cnt !== 16'd0) begin
         miscompares++;
         $display("FAIL rm_restart: valid %b lane %0d drops %0d required 1 0 0", m_valid, m_lane, drop_cnt);
      end
      for (int i = 0; i < 60 && (got_q.size() - chk_idx) < exp_q.size(); i++) cyc();
      repeat (3) cyc();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (chk_idx >= got_q.size()) begin
            miscompares++; $display("FAIL rm_stream: pixel missing, required %h", e);
         end else begin
            if (got_q[chk_idx] !== e) begin
               miscompares++; $display("FAIL rm_stream: got %h required %h", got_q[chk_idx], e);
            end
            chk_idx++;
         end
      end
      vectors++;
      if (got_q.size() != chk_idx) begin
         miscompares++; $display("FAIL rm_extra: %0d extra pixels, required 0", got_q.size() - chk_idx);
         chk_idx = got_q.size();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_carry_sat();
      test_back_to_back();
      test_backpressure();
      test_overflow();
      test_full_pop();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
